hw_bench_latency_calc: RTL and testbench
========================================

# hw_bench_latency_calc

Pairs command and status timestamps from the hw_bench tap stage and produces per-command round-trip latency. Each command timestamp is queued in order, and each status timestamp retires the oldest queued one. The block emits the cycle delta on an AXI4-Stream output and keeps running count, min, max and sum statistics for host readout. It sits directly downstream of the benchmark tap's `cmdTimestamp` and `stsTimestamp` streams.

## Interface
- TS_WIDTH, 64, timestamp and latency width
- FIFO_DEPTH, 16, pending-command queue depth; power of two, ≥2
- SUM_WIDTH, 80, latency accumulator width
- CNT_WIDTH, 32, sample counter width

Clock and reset are ap_clk and areset; areset is synchronous and active-high.

- ap_clk  in  1  clock
- areset  in  1  synchronous active-high reset
- cmdTs_tvalid/tready  in/out  1  command timestamp handshake
- cmdTs_tdata  in  TS_WIDTH  command timestamp
- cmdTs_tlast  in  1  ignored
- stsTs_tvalid/tready  in/out  1  status timestamp handshake
- stsTs_tdata  in  TS_WIDTH  status timestamp
- stsTs_tlast  in  1  ignored
- lat_tvalid/tready  out/in  1  latency output handshake
- lat_tdata  out  TS_WIDTH  latency in cycles
- lat_tlast  out  1  constant 1 while lat_tvalid (single-beat records)
- stat_clear  in  1  synchronous statistics clear pulse
- stat_count  out  CNT_WIDTH  samples recorded, saturating
- stat_min  out  TS_WIDTH  smallest latency recorded
- stat_max  out  TS_WIDTH  largest latency recorded
- stat_sum  out  SUM_WIDTH  sum of latencies, saturating
- pending  out  log2(FIFO_DEPTH)+1  queued command timestamps

## Operation
- **Command FIFO**
  - Circular buffer with registered full/empty flags.
  - cmdTs_tready = !full, taken from the registered flag.
  - A push occurs on cmdTs_tvalid & cmdTs_tready.
  - When full, no push is accepted, even if a pop happens in the same cycle.
- **Pairing**
  - stsTs_tready = !empty & (!lat_tvalid | lat_tready), with empty taken from the registered flag.
  - An sts handshake pops the FIFO head and computes delta = stsTs_tdata − head, modulo 2^TS_WIDTH. Wrap-around of the free-running timestamp therefore yields the correct delta.
  - When the FIFO is empty, status is stalled, not dropped. There is no bypass: a cmd pushed into an empty FIFO is pairable from the following cycle.
  - A push and a pop in the same cycle are legal when the FIFO is neither empty nor full. pending is unchanged in that case.
- **Output register**
  - On an sts handshake: lat_tdata ← delta and lat_tvalid ← 1.
  - lat_tvalid clears on lat_tready when no new sts handshake occurs in that cycle.
  - lat_tdata is held stable while lat_tvalid & !lat_tready.
- **Statistics** (updated on the sts handshake)
  - count increments and saturates at all-ones.
  - sum ← sum + delta, saturating at all-ones.
  - min ← min(min, delta) and max ← max(max, delta).
- **stat_clear**
  - Resets count=0, sum=0, min=all-ones, max=0.
  - If a sample arrives in the same cycle, clear wins and the sample seeds the fresh stats: count=1, min=max=sum=delta.
  - stat_clear does not affect the FIFO or the lat stream.
- **Reset**
  - FIFO emptied and pending=0.
  - cmdTs_tready=0 in the reset cycle, then 1.
  - stsTs_tready=0 and lat_tvalid=0.
  - lat_tdata=0 and lat_tlast=0.
  - Statistics take the same values as a clear.
  - Reset mid-transaction discards queued timestamps and any unaccepted output.

## Timing
- Latency from sts handshake to lat_tvalid is 1 cycle; the statistics outputs update in that same cycle.
- Full throughput is one pair per cycle when lat_tready is held at 1.
- pending, full and empty are registered and update one cycle after the push or pop.
- All outputs are registered except cmdTs_tready and stsTs_tready, which are single-gate functions of registered flags and lat_tready.

## Test plan
- **Basic pair.** cmd ts=100, then sts ts=142 → lat_tdata=42 with lat_tlast=1, one cycle after the sts handshake. count=1, min=max=sum=42.
- **In-order queueing.** cmds 10, 20, 30, then sts 50, 55, 90 → lats 40, 35, 60. min=35, max=60, sum=135, pending returns to 0.
- **Wrap-around.** cmd ts=2^64−5, sts ts=3 → lat=8.
- **Full/empty boundary.**
  - 16 cmds with no sts → cmdTs_tready=0 and pending=16; the 17th is held.
  - An sts arriving before any cmd sees stsTs_tready=0 until the cycle after the first cmd push.
- **Backpressure.** lat_tready=0 with one result pending → stsTs_tready=0 and lat_tdata stable. Releasing lat_tready → next result one cycle later, with no loss or duplication.
- **Clear collision.** stat_clear asserted in the same cycle as a sample with delta=7 → count=1, min=max=sum=7. A later areset → count=0, min=all-ones, lat_tvalid=0.

Source files
------------

// File: rtl/hw_bench_latency_calc.sv
// hw_bench_latency_calc
//
// Pairs command timestamps with status timestamps in arrival order and
// reports the round-trip latency of each command in cycles. Command
// timestamps are queued in a circular buffer. Each accepted status
// timestamp retires the oldest queued command and produces one latency
// record on the lat stream. The same record also updates the running
// count/min/max/sum statistics that the host reads back.
//
// Ports
//   ap_clk, areset       clock, synchronous active-high reset
//   cmdTs_*              command timestamp stream in (tlast ignored)
//   stsTs_*              status timestamp stream in (tlast ignored)
//   lat_*                latency stream out, single-beat records (tlast=1)
//   stat_clear           synchronous statistics clear pulse
//   stat_count/min/max/sum  running statistics, count and sum saturate
//   pending              number of queued command timestamps
module hw_bench_latency_calc #(
  parameter int TS_WIDTH   = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int SUM_WIDTH  = 80,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          cmdTs_tvalid,
  output logic                          cmdTs_tready,
  input  logic [TS_WIDTH-1:0]           cmdTs_tdata,
  input  logic                          cmdTs_tlast,
  input  logic                          stsTs_tvalid,
  output logic                          stsTs_tready,
  input  logic [TS_WIDTH-1:0]           stsTs_tdata,
  input  logic                          stsTs_tlast,
  output logic                          lat_tvalid,
  input  logic                          lat_tready,
  output logic [TS_WIDTH-1:0]           lat_tdata,
  output logic                          lat_tlast,
  input  logic                          stat_clear,
  output logic [CNT_WIDTH-1:0]          stat_count,
  output logic [TS_WIDTH-1:0]           stat_min,
  output logic [TS_WIDTH-1:0]           stat_max,
  output logic [SUM_WIDTH-1:0]          stat_sum,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // Saturating increment of the sample counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] a);
    return (&a) ? a : a + CNT_WIDTH'(1);
  endfunction

  // Saturating accumulate of one latency into the sum; the extra top bit
  // of the widened add is the overflow indicator.
  function automatic logic [SUM_WIDTH-1:0] sat_add_sum(input logic [SUM_WIDTH-1:0] a,
                                                       input logic [TS_WIDTH-1:0]  b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + (SUM_WIDTH+1)'(b);
    return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
  endfunction

  // tlast on both inputs carries no meaning for single-beat timestamps.
  logic unused_tlast;
  assign unused_tlast = cmdTs_tlast ^ stsTs_tlast;

  logic [TS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic                lat_tvalid_q, lat_tvalid_d;
  logic [TS_WIDTH-1:0] lat_tdata_q, lat_tdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [TS_WIDTH-1:0]  min_q, min_d;
  logic [TS_WIDTH-1:0]  max_q, max_d;

  logic                push, pop;
  logic [TS_WIDTH-1:0] delta;

  // Ready is forced low while reset is held so nothing is accepted in the
  // reset cycle; afterwards it is purely the registered full flag.
  assign cmdTs_tready = ~full_q & ~areset;
  assign stsTs_tready = ~empty_q & (~lat_tvalid_q | lat_tready);

  assign push  = cmdTs_tvalid & cmdTs_tready;
  assign pop   = stsTs_tvalid & stsTs_tready;
  // Modulo subtraction handles a wrapped free-running timestamp.
  assign delta = stsTs_tdata - mem_q[rd_ptr_q];

  // ---- Stage: command queue bookkeeping ----
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + PW'(1);
    end else if (!push && pop) begin
      count_d = count_q - PW'(1);
    end
    full_d  = (count_d == PW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmdTs_tdata;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // ---- Stage: latency output register and statistics ----
  always_comb begin
    lat_tvalid_d = lat_tvalid_q;
    lat_tdata_d  = lat_tdata_q;
    if (pop) begin
      lat_tvalid_d = 1'b1;
      lat_tdata_d  = delta;
    end else if (lat_tready) begin
      lat_tvalid_d = 1'b0;
    end

    // A clear and a sample in the same cycle: clear first, then the sample
    // seeds the fresh statistics.
    cnt_d = stat_clear ? '0 : cnt_q;
    sum_d = stat_clear ? '0 : sum_q;
    min_d = stat_clear ? {TS_WIDTH{1'b1}} : min_q;
    max_d = stat_clear ? '0 : max_q;
    if (pop) begin
      cnt_d = sat_inc_cnt(cnt_d);
      sum_d = sat_add_sum(sum_d, delta);
      if (delta < min_d) min_d = delta;
      if (delta > max_d) max_d = delta;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      lat_tvalid_q <= 1'b0;
      lat_tdata_q  <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      min_q        <= {TS_WIDTH{1'b1}};
      max_q        <= '0;
    end else begin
      lat_tvalid_q <= lat_tvalid_d;
      lat_tdata_q  <= lat_tdata_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      min_q        <= min_d;
      max_q        <= max_d;
    end
  end

  assign lat_tvalid = lat_tvalid_q;
  assign lat_tdata  = lat_tdata_q;
  assign lat_tlast  = lat_tvalid_q;
  assign stat_count = cnt_q;
  assign stat_sum   = sum_q;
  assign stat_min   = min_q;
  assign stat_max   = max_q;
  assign pending    = count_q;

endmodule

// File: tb/tb_hw_bench_latency_calc.sv
`timescale 1ns/1ps
module tb_hw_bench_latency_calc;

  localparam int TS_WIDTH   = 64;
  localparam int FIFO_DEPTH = 16;
  localparam int SUM_WIDTH  = 80;
  localparam int CNT_WIDTH  = 32;
  localparam int PW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SUM_WIDTH-1:0] SUM_MAX = {SUM_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [TS_WIDTH-1:0]  TS_MAX  = {TS_WIDTH{1'b1}};

  logic                 ap_clk = 1'b0;
  logic                 areset = 1'b1;
  logic                 cmdTs_tvalid = 1'b0;
  logic                 cmdTs_tready;
  logic [TS_WIDTH-1:0]  cmdTs_tdata = '0;
  logic                 cmdTs_tlast = 1'b0;
  logic                 stsTs_tvalid = 1'b0;
  logic                 stsTs_tready;
  logic [TS_WIDTH-1:0]  stsTs_tdata = '0;
  logic                 stsTs_tlast = 1'b0;
  logic                 lat_tvalid;
  logic                 lat_tready = 1'b1;
  logic [TS_WIDTH-1:0]  lat_tdata;
  logic                 lat_tlast;
  logic                 stat_clear = 1'b0;
  logic [CNT_WIDTH-1:0] stat_count;
  logic [TS_WIDTH-1:0]  stat_min;
  logic [TS_WIDTH-1:0]  stat_max;
  logic [SUM_WIDTH-1:0] stat_sum;
  logic [PW-1:0]        pending;

  hw_bench_latency_calc #(
    .TS_WIDTH(TS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
    .SUM_WIDTH(SUM_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .ap_clk(ap_clk), .areset(areset),
    .cmdTs_tvalid(cmdTs_tvalid), .cmdTs_tready(cmdTs_tready),
    .cmdTs_tdata(cmdTs_tdata), .cmdTs_tlast(cmdTs_tlast),
    .stsTs_tvalid(stsTs_tvalid), .stsTs_tready(stsTs_tready),
    .stsTs_tdata(stsTs_tdata), .stsTs_tlast(stsTs_tlast),
    .lat_tvalid(lat_tvalid), .lat_tready(lat_tready),
    .lat_tdata(lat_tdata), .lat_tlast(lat_tlast),
    .stat_clear(stat_clear), .stat_count(stat_count),
    .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum),
    .pending(pending)
  );

  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: an ordered list of outstanding command timestamps, the
  // list of latency records still owed on the output, and plain statistics.
  logic [TS_WIDTH-1:0]  cq[$];
  logic [TS_WIDTH-1:0]  sbq[$];
  logic [CNT_WIDTH-1:0] m_cnt = '0;
  logic [SUM_WIDTH-1:0] m_sum = '0;
  logic [TS_WIDTH-1:0]  m_min = TS_MAX;
  logic [TS_WIDTH-1:0]  m_max = '0;
  bit                   m_lv  = 1'b0;

  always @(negedge ap_clk) begin
    logic [TS_WIDTH-1:0] d;
    bit exp_cr, exp_sr, cpush, spop;
    if (areset) begin
      cq.delete();
      sbq.delete();
      m_cnt = '0; m_sum = '0; m_min = TS_MAX; m_max = '0; m_lv = 1'b0;
    end else begin
      exp_cr = cq.size() < FIFO_DEPTH;
      exp_sr = (cq.size() > 0) && (!m_lv || lat_tready);
      chk("pending",      128'(pending),      128'(cq.size()));
      chk("cmdTs_tready", 128'(cmdTs_tready), 128'(exp_cr));
      chk("stsTs_tready", 128'(stsTs_tready), 128'(exp_sr));
      chk("lat_tvalid",   128'(lat_tvalid),   128'(m_lv));
      chk("lat_tlast",    128'(lat_tlast),    128'(m_lv));
      chk("stat_count",   128'(stat_count),   128'(m_cnt));
      chk("stat_sum",     128'(stat_sum),     128'(m_sum));
      chk("stat_min",     128'(stat_min),     128'(m_min));
      chk("stat_max",     128'(stat_max),     128'(m_max));

      cpush = cmdTs_tvalid && exp_cr;
      spop  = stsTs_tvalid && exp_sr;
      if (stat_clear) begin
        m_cnt = '0; m_sum = '0; m_min = TS_MAX; m_max = '0;
      end
      if (spop) begin
        d = stsTs_tdata - cq.pop_front();
        sbq.push_back(d);
        if (m_cnt != CNT_MAX) m_cnt++;
        if (SUM_MAX - m_sum < SUM_WIDTH'(d)) m_sum = SUM_MAX;
        else m_sum = m_sum + SUM_WIDTH'(d);
        if (d < m_min) m_min = d;
        if (d > m_max) m_max = d;
      end
      if (cpush) cq.push_back(cmdTs_tdata);
      if (spop) m_lv = 1'b1;
      else if (lat_tready) m_lv = 1'b0;
    end
  end

  // Monitor: every presented latency record must match the oldest owed one.
  always @(negedge ap_clk) begin
    if (!areset && lat_tvalid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lat_unexpected: got %0h expected no record at %0t", lat_tdata, $time);
      end else begin
        chk("lat_tdata", 128'(lat_tdata), 128'(sbq[0]));
        if (lat_tready) void'(sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_cmdTs_tready", 128'(cmdTs_tready), 128'(0));
    chk("rst_stsTs_tready", 128'(stsTs_tready), 128'(0));
    chk("rst_lat_tvalid",   128'(lat_tvalid),   128'(0));
    chk("rst_lat_tdata",    128'(lat_tdata),    128'(0));
    chk("rst_lat_tlast",    128'(lat_tlast),    128'(0));
    chk("rst_pending",      128'(pending),      128'(0));
    chk("rst_count",        128'(stat_count),   128'(0));
    chk("rst_min",          128'(stat_min),     128'(TS_MAX));
    chk("rst_max",          128'(stat_max),     128'(0));
    chk("rst_sum",          128'(stat_sum),     128'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    cmdTs_tvalid = 1'b0; stsTs_tvalid = 1'b0; stat_clear = 1'b0; lat_tready = 1'b1;
    tick();
    @(negedge ap_clk);
    reset_checks();
    tick();
    areset = 1'b0;
  endtask

  task automatic send_cmd(input logic [TS_WIDTH-1:0] ts);
    int n;
    n = 0;
    cmdTs_tvalid = 1'b1;
    cmdTs_tdata  = ts;
    @(negedge ap_clk);
    while (!cmdTs_tready && n < 100) begin
      n++;
      @(negedge ap_clk);
    end
    chk("cmd_handshake", 128'(cmdTs_tready), 128'(1));
    tick();
    cmdTs_tvalid = 1'b0;
  endtask

  task automatic send_sts(input logic [TS_WIDTH-1:0] ts, input bit clr);
    int n;
    n = 0;
    stsTs_tvalid = 1'b1;
    stsTs_tdata  = ts;
    stat_clear   = clr;
    @(negedge ap_clk);
    while (!stsTs_tready && n < 100) begin
      n++;
      @(negedge ap_clk);
    end
    chk("sts_handshake", 128'(stsTs_tready), 128'(1));
    tick();
    stsTs_tvalid = 1'b0;
    stat_clear   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Basic pair
    send_cmd(64'd100);
    send_sts(64'd142, 1'b0);
    chk("basic_lat_tvalid", 128'(lat_tvalid), 128'(1));
    chk("basic_lat_tdata",  128'(lat_tdata),  128'(42));
    chk("basic_lat_tlast",  128'(lat_tlast),  128'(1));
    chk("basic_count",      128'(stat_count), 128'(1));
    chk("basic_min",        128'(stat_min),   128'(42));
    chk("basic_max",        128'(stat_max),   128'(42));
    chk("basic_sum",        128'(stat_sum),   128'(42));

    // In-order queueing
    do_reset();
    send_cmd(64'd10); send_cmd(64'd20); send_cmd(64'd30);
    chk("order_pending3", 128'(pending), 128'(3));
    send_sts(64'd50, 1'b0); send_sts(64'd55, 1'b0); send_sts(64'd90, 1'b0);
    chk("order_last_lat", 128'(lat_tdata),  128'(60));
    chk("order_count",    128'(stat_count), 128'(3));
    chk("order_min",      128'(stat_min),   128'(35));
    chk("order_max",      128'(stat_max),   128'(60));
    chk("order_sum",      128'(stat_sum),   128'(135));
    chk("order_pending0", 128'(pending),    128'(0));

    // Wrap-around
    do_reset();
    send_cmd(64'hFFFF_FFFF_FFFF_FFFB);
    send_sts(64'd3, 1'b0);
    chk("wrap_lat", 128'(lat_tdata), 128'(8));

    // Full boundary, including a pop while full with a push waiting
    do_reset();
    for (int i = 0; i < FIFO_DEPTH; i++) send_cmd(TS_WIDTH'(i * 3));
    chk("full_cmd_rdy", 128'(cmdTs_tready), 128'(0));
    chk("full_pending", 128'(pending),      128'(16));
    cmdTs_tvalid = 1'b1;
    cmdTs_tdata  = 64'd999;
    repeat (3) tick();
    chk("full_held_pending", 128'(pending), 128'(16));
    send_sts(64'd1000, 1'b0);
    chk("full_pop_no_push", 128'(pending), 128'(15));
    @(negedge ap_clk);
    chk("full_rdy_again", 128'(cmdTs_tready), 128'(1));
    tick();
    cmdTs_tvalid = 1'b0;
    chk("full_refill", 128'(pending), 128'(16));
    for (int i = 0; i < FIFO_DEPTH; i++) send_sts(TS_WIDTH'(2000 + 7 * i), 1'b0);
    chk("full_drained", 128'(pending), 128'(0));

    // Empty boundary: status waits for the first command
    do_reset();
    stsTs_tvalid = 1'b1;
    stsTs_tdata  = 64'd20;
    repeat (3) begin
      @(negedge ap_clk);
      chk("empty_sts_rdy0", 128'(stsTs_tready), 128'(0));
    end
    tick();
    send_cmd(64'd5);
    chk("empty_sts_rdy1", 128'(stsTs_tready), 128'(1));
    tick();
    stsTs_tvalid = 1'b0;
    chk("empty_lat", 128'(lat_tdata), 128'(15));

    // Backpressure
    do_reset();
    lat_tready = 1'b0;
    send_cmd(64'd1); send_cmd(64'd2);
    send_sts(64'd11, 1'b0);
    stsTs_tvalid = 1'b1;
    stsTs_tdata  = 64'd22;
    repeat (3) begin
      @(negedge ap_clk);
      chk("bp_sts_rdy0", 128'(stsTs_tready), 128'(0));
      chk("bp_lat_hold", 128'(lat_tdata),    128'(10));
    end
    tick();
    lat_tready = 1'b1;
    @(negedge ap_clk);
    chk("bp_sts_rdy1", 128'(stsTs_tready), 128'(1));
    tick();
    stsTs_tvalid = 1'b0;
    chk("bp_next_vld", 128'(lat_tvalid), 128'(1));
    chk("bp_next_lat", 128'(lat_tdata),  128'(20));
    tick();
    chk("bp_idle_vld", 128'(lat_tvalid), 128'(0));

    // Clear collision, then reset
    do_reset();
    send_cmd(64'd0);
    send_sts(64'd50, 1'b0);
    tick();
    chk("clr_pre_sum", 128'(stat_sum), 128'(50));
    send_cmd(64'd100);
    send_sts(64'd107, 1'b1);
    chk("clr_count", 128'(stat_count), 128'(1));
    chk("clr_min",   128'(stat_min),   128'(7));
    chk("clr_max",   128'(stat_max),   128'(7));
    chk("clr_sum",   128'(stat_sum),   128'(7));
    do_reset();

    // Randomized traffic against the model, with one reset mid-stream
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      cmdTs_tvalid = ($urandom_range(0, 99) < 60);
      cmdTs_tdata  = {$urandom, $urandom};
      cmdTs_tlast  = $urandom_range(0, 1) == 1;
      stsTs_tvalid = ($urandom_range(0, 99) < 55);
      stsTs_tdata  = {$urandom, $urandom};
      stsTs_tlast  = $urandom_range(0, 1) == 1;
      lat_tready   = ($urandom_range(0, 99) < 70);
      stat_clear   = ($urandom_range(0, 99) < 3);
      tick();
    end
    cmdTs_tvalid = 1'b0; stsTs_tvalid = 1'b0; stat_clear = 1'b0; lat_tready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
